mem_arbiter: RTL
================

# mem_arbiter

Sequences the single unified main-memory port between the instruction-cache refill path, the data-cache refill path and data-side write-through stores. It sits between both cache controllers and main memory, and its completion pulses are what release the IF/ID and MEM stalls. Each grant is held until its transaction completes. The block issues block-fill reads one word per cycle and steers returning data into the requesting cache.

## Interface
Parameters:
- BLOCK_WORDS, 8, 16-bit words per cache block; must be a power of two, minimum 2.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- icache_miss  in  1  I-cache requests a block fill; held until icache_fill_done.
- icache_miss_addr  in  16  byte address of the missed instruction.
- dcache_miss  in  1  D-cache requests a block fill; held until dcache_fill_done.
- dcache_miss_addr  in  16  byte address of the missed data.
- dcache_wr  in  1  write-through store request; held until dcache_wr_ack.
- dcache_wr_addr  in  16  store byte address.
- dcache_wr_data  in  16  store data.
- mem_en  out  1  memory access strobe, one word per cycle.
- mem_wr  out  1  1 = write, 0 = read.
- mem_addr  out  16  word-aligned memory address.
- mem_wdata  out  16  write data; equals dcache_wr_data when mem_wr=1, else 0.
- mem_data_valid  in  1  read data valid; fixed pipelined latency, in issue order.
- icache_fill_we  out  1  write returning word into I-cache.
- dcache_fill_we  out  1  write returning word into D-cache.
- fill_addr  out  16  word-aligned address of the returning word.
- icache_fill_done  out  1  one-cycle pulse, I-fill complete.
- dcache_fill_done  out  1  one-cycle pulse, D-fill complete.
- dcache_wr_ack  out  1  one-cycle pulse, store issued.

## Operation
- States: IDLE, WRITE, DFILL, IFILL. On reset: IDLE, counters 0, every output 0.
- Arbitration happens in IDLE only, with fixed priority dcache_wr > dcache_miss > icache_miss. The data side is older in program order.
- IDLE -> WRITE: for one cycle drive mem_en=1, mem_wr=1, mem_addr=dcache_wr_addr with bit0 cleared, mem_wdata=dcache_wr_data, dcache_wr_ack=1. Then return to IDLE.
- IDLE -> DFILL/IFILL: latch block base = miss_addr with the low log2(BLOCK_WORDS)+1 bits cleared. Clear issue_cnt and recv_cnt.
- Issue phase: while issue_cnt < BLOCK_WORDS, drive mem_en=1, mem_wr=0, mem_addr = base + 2*issue_idx. issue_cnt increments every cycle.
- Receive phase:
  - Each mem_data_valid while in a fill state asserts that cache's fill_we with fill_addr = base + 2*recv_idx. recv_cnt then increments.
  - Valid on the final word pulses the fill_done for that cache, and the next state is IDLE.
- Issue and receive overlap. mem_data_valid is ignored in IDLE and WRITE.
- A requester deasserting its request mid-fill does not abort the fill; it completes and still pulses done.
- New requests arriving mid-transaction wait; they are evaluated in the IDLE cycle after completion.
- Asynchronous rst mid-fill aborts immediately. Main memory shares rst, so no stale read data can return after reset.

## Timing
- Store: request seen in IDLE at cycle N; mem write and ack at N+1; next arbitration at N+2.
- Fill: granted at cycle N; words issued N+1..N+BLOCK_WORDS.
- With memory latency L, the last word and the done pulse land at cycle N+BLOCK_WORDS+L. The next arbitration is one cycle later.
- Outputs are decoded from registered state and counters, plus the combinational mem_data_valid qualification for fill_we.
- Every grant has one IDLE cycle of dead time after it completes.

## Configuration
- MEMARB_CRIT_WORD_FIRST_EN defined:
  - issue_idx = (miss word index + issue_cnt) mod BLOCK_WORDS, wrapping past the block end to word 0.
  - recv_idx follows the same rotation, so the missed word returns first.
- Undefined: issue_idx = issue_cnt and recv_idx = recv_cnt, always starting at word 0 of the block.

## Test plan
- Reset mid-IFILL after 3 words issued: all outputs go 0 immediately; state IDLE; the next icache_miss restarts at issue_cnt 0.
- Lone icache_miss at addr 0x1236, L=4, macro undefined:
  - mem_addr 0x1230,0x1232..0x123E on cycles N+1..N+8.
  - icache_fill_we with fill_addr 0x1230..0x123E on N+5..N+12.
  - icache_fill_done at N+12.
- Same stimulus with MEMARB_CRIT_WORD_FIRST_EN defined: issue order 0x1236,0x1238,0x123A,0x123C,0x123E,0x1230,0x1232,0x1234; fill_addr follows the same order.
- Simultaneous dcache_wr(0x4000, 0xBEEF), dcache_miss(0x2000) and icache_miss(0x1000):
  - Write at N+1 with ack.
  - D-fill granted N+2; dcache_fill_done at N+14.
  - I-fill granted N+15; no icache_fill_we during DFILL.
- icache_miss dropped after 2 cycles of IFILL: all 8 words are still issued and returned, and icache_fill_done pulses once.
- dcache_wr raised during DFILL: no mem_wr until DFILL done; write issued in the cycle after the IDLE arbitration cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the unified main-memory port between I-cache fills, D-cache fills and write-through stores.
// Optional MEMARB_CRIT_WORD_FIRST_EN: fills start at the missed word and wrap around the block.
module mem_arbiter #(
  parameter int unsigned BLOCK_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        icache_miss,
  input  logic [15:0] icache_miss_addr,
  input  logic        dcache_miss,
  input  logic [15:0] dcache_miss_addr,
  input  logic        dcache_wr,
  input  logic [15:0] dcache_wr_addr,
  input  logic [15:0] dcache_wr_data,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_data_valid,
  output logic        icache_fill_we,
  output logic        dcache_fill_we,
  output logic [15:0] fill_addr,
  output logic        icache_fill_done,
  output logic        dcache_fill_done,
  output logic        dcache_wr_ack
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned IW = $clog2(BLOCK_WORDS);
  localparam int unsigned CW = IW + 1;
  localparam logic [AW-1:0] BASE_MASK = ~AW'((32'd1 << (IW + 1)) - 32'd1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(BLOCK_WORDS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_DFILL,
    ST_IFILL
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] issue_cnt_q, issue_cnt_d;
  logic [CW-1:0] recv_cnt_q, recv_cnt_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic [IW-1:0] issue_idx, recv_idx;

`ifdef MEMARB_CRIT_WORD_FIRST_EN
  logic [IW-1:0] widx_q, widx_d;

  // Rotation starts at the missed word; IW-bit addition wraps within the block.
  assign issue_idx = widx_q + issue_cnt_q[IW-1:0];
  assign recv_idx  = widx_q + recv_cnt_q[IW-1:0];
`else
  assign issue_idx = issue_cnt_q[IW-1:0];
  assign recv_idx  = recv_cnt_q[IW-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      base_q      <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
`ifdef MEMARB_CRIT_WORD_FIRST_EN
      widx_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      base_q      <= base_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
`ifdef MEMARB_CRIT_WORD_FIRST_EN
      widx_q      <= widx_d;
`endif
    end
  end

  // Arbitration, issue/receive sequencing and output decode.
  always_comb begin
    state_d          = state_q;
    issue_cnt_d      = issue_cnt_q;
    recv_cnt_d       = recv_cnt_q;
    base_d           = base_q;
    wr_addr_d        = wr_addr_q;
    wr_data_d        = wr_data_q;
`ifdef MEMARB_CRIT_WORD_FIRST_EN
    widx_d           = widx_q;
`endif
    mem_en           = 1'b0;
    mem_wr           = 1'b0;
    mem_addr         = '0;
    mem_wdata        = '0;
    icache_fill_we   = 1'b0;
    dcache_fill_we   = 1'b0;
    fill_addr        = '0;
    icache_fill_done = 1'b0;
    dcache_fill_done = 1'b0;
    dcache_wr_ack    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        issue_cnt_d = '0;
        recv_cnt_d  = '0;
        // Data side is older in program order, stores before fills.
        if (dcache_wr) begin
          state_d   = ST_WRITE;
          wr_addr_d = dcache_wr_addr & ~AW'(1);
          wr_data_d = dcache_wr_data;
        end else if (dcache_miss) begin
          state_d = ST_DFILL;
          base_d  = dcache_miss_addr & BASE_MASK;
`ifdef MEMARB_CRIT_WORD_FIRST_EN
          widx_d  = dcache_miss_addr[IW:1];
`endif
        end else if (icache_miss) begin
          state_d = ST_IFILL;
          base_d  = icache_miss_addr & BASE_MASK;
`ifdef MEMARB_CRIT_WORD_FIRST_EN
          widx_d  = icache_miss_addr[IW:1];
`endif
        end
      end

      ST_WRITE: begin
        mem_en        = 1'b1;
        mem_wr        = 1'b1;
        mem_addr      = wr_addr_q;
        mem_wdata     = wr_data_q;
        dcache_wr_ack = 1'b1;
        state_d       = ST_IDLE;
      end

      ST_DFILL, ST_IFILL: begin
        if (issue_cnt_q < CNT_FULL) begin
          mem_en      = 1'b1;
          mem_addr    = base_q | AW'({issue_idx, 1'b0});
          issue_cnt_d = issue_cnt_q + CW'(1);
        end
        if (mem_data_valid) begin
          icache_fill_we = (state_q == ST_IFILL);
          dcache_fill_we = (state_q == ST_DFILL);
          fill_addr      = base_q | AW'({recv_idx, 1'b0});
          recv_cnt_d     = recv_cnt_q + CW'(1);
          if (recv_cnt_q == CNT_LAST) begin
            icache_fill_done = (state_q == ST_IFILL);
            dcache_fill_done = (state_q == ST_DFILL);
            state_d          = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule
